// File: rtl/ret_shadow_stack.sv
// Shadow return-address stack: calls push link values, returns pop and compare.
// Define RET_SHADOW_STACK_STICKY_EN to make faults sticky until reset.
module ret_shadow_stack #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned VLEN  = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       en_i,
    input  logic                       clr_i,
    input  logic                       debug_mode_i,
    input  logic [1:0]                 priv_lvl_i,
    input  logic                       valid_i,
    input  logic                       is_call_i,
    input  logic                       is_return_i,
    input  logic [VLEN-1:0]            link_addr_i,
    input  logic [VLEN-1:0]            ret_target_i,
    output logic                       fault_o,
    output logic [VLEN-1:0]            fault_addr_o,
    output logic [$clog2(DEPTH):0]     depth_o,
    output logic                       overflow_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [1:0]  PRIV_LVL_U = 2'b00;

`ifdef RET_SHADOW_STACK_STICKY_EN
    typedef enum logic {RUN, FAULT} state_e;
    state_e state_q, state_d;
`endif

    logic [VLEN-1:0] stack_q [DEPTH];
    logic [PW-1:0]   topPtr_q, topPtr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [7:0]      lost_q, lost_d;
    logic            overflow_q, overflow_d;
    logic            fault_q, fault_d;
    logic [VLEN-1:0] faultAddr_q, faultAddr_d;

    logic            act, frozen, faultNow, isFull, isEmpty;
    logic            pushOp, popOp, swapOp;
    logic            wrEn;
    logic [PW-1:0]   wrIdx;
    logic [VLEN-1:0] topEntry;

    assign act     = valid_i & en_i & ~debug_mode_i & (priv_lvl_i == PRIV_LVL_U);
    assign pushOp  = is_call_i & ~is_return_i;
    assign popOp   = is_return_i & ~is_call_i;
    assign swapOp  = is_call_i & is_return_i;
    assign isFull  = (count_q == CW'(DEPTH));
    assign isEmpty = (count_q == '0);
    // The array is a flop bank read combinationally, so a push in cycle N is
    // already visible to a return in cycle N+1 without a separate bypass.
    assign topEntry = stack_q[topPtr_q];

`ifdef RET_SHADOW_STACK_STICKY_EN
    assign frozen = (state_q == FAULT);
`else
    assign frozen = 1'b0;
`endif

    always_comb begin
        topPtr_d    = topPtr_q;
        count_d     = count_q;
        lost_d      = lost_q;
        overflow_d  = overflow_q;
        faultNow    = 1'b0;
        wrEn        = 1'b0;
        wrIdx       = topPtr_q;
        if (!frozen) begin
            if (clr_i) begin
                topPtr_d   = '0;
                count_d    = '0;
                lost_d     = '0;
                overflow_d = 1'b0;
            end else if (act) begin
                // A swap on an empty stack has nothing to check and degrades to a push.
                if (pushOp || (swapOp && isEmpty)) begin
                    wrEn     = 1'b1;
                    wrIdx    = topPtr_q + 1'b1;
                    topPtr_d = topPtr_q + 1'b1;
                    if (isFull) begin
                        overflow_d = 1'b1;
                        if (lost_q != 8'hFF) lost_d = lost_q + 8'd1;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end else if (popOp || swapOp) begin
                    if (!isEmpty) begin
                        faultNow = (topEntry != ret_target_i);
                        if (popOp) begin
                            topPtr_d = topPtr_q - 1'b1;
                            count_d  = count_q - 1'b1;
                        end else begin
                            wrEn = 1'b1;
                        end
                    end else if (lost_q != 8'd0) begin
                        lost_d = lost_q - 8'd1;
                    end else begin
                        faultNow = 1'b1;
                    end
                end
            end
        end
`ifdef RET_SHADOW_STACK_STICKY_EN
        fault_d = fault_q | faultNow;
        state_d = faultNow ? FAULT : state_q;
`else
        fault_d = faultNow;
`endif
        faultAddr_d = faultNow ? ret_target_i : faultAddr_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
`ifdef RET_SHADOW_STACK_STICKY_EN
            state_q <= RUN;
`endif
            topPtr_q    <= '0;
            count_q     <= '0;
            lost_q      <= '0;
            overflow_q  <= 1'b0;
            fault_q     <= 1'b0;
            faultAddr_q <= '0;
        end else begin
`ifdef RET_SHADOW_STACK_STICKY_EN
            state_q <= state_d;
`endif
            topPtr_q    <= topPtr_d;
            count_q     <= count_d;
            lost_q      <= lost_d;
            overflow_q  <= overflow_d;
            fault_q     <= fault_d;
            faultAddr_q <= faultAddr_d;
        end
    end

    // Entry storage carries no reset; contents are meaningless until pushed.
    always_ff @(posedge clk_i) begin
        if (!rst_i && wrEn) stack_q[wrIdx] <= link_addr_i;
    end

    assign fault_o      = fault_q;
    assign fault_addr_o = faultAddr_q;
    assign depth_o      = count_q;
    assign overflow_o   = overflow_q;

endmodule

// File: tb/tb_ret_shadow_stack.sv
// Directed self-checking bench for ret_shadow_stack (DEPTH=8, VLEN=32).
// Sticky-fault expectations are selected with RET_SHADOW_STACK_STICKY_EN.
module tb_ret_shadow_stack;

    logic        clk_i = 1'b0;
    logic        rst_i, en_i, clr_i, debug_mode_i;
    logic [1:0]  priv_lvl_i;
    logic        valid_i, is_call_i, is_return_i;
    logic [31:0] link_addr_i, ret_target_i;
    logic        fault_o, overflow_o;
    logic [31:0] fault_addr_o;
    logic [3:0]  depth_o;

    int compared   = 0;
    int mismatched = 0;

    ret_shadow_stack #(.DEPTH(8), .VLEN(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .clr_i(clr_i),
        .debug_mode_i(debug_mode_i), .priv_lvl_i(priv_lvl_i),
        .valid_i(valid_i), .is_call_i(is_call_i), .is_return_i(is_return_i),
        .link_addr_i(link_addr_i), .ret_target_i(ret_target_i),
        .fault_o(fault_o), .fault_addr_o(fault_addr_o),
        .depth_o(depth_o), .overflow_o(overflow_o)
    );

    always #5 clk_i = ~clk_i;

    // Compare one observed value against its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Present one event for one cycle; outputs are sampled 1ns after the edge.
    task automatic applyStimulus(input logic v, input logic call, input logic ret,
                                 input logic [31:0] link, input logic [31:0] target,
                                 input logic clr = 1'b0);
        valid_i = v; is_call_i = call; is_return_i = ret;
        link_addr_i = link; ret_target_i = target; clr_i = clr;
        @(posedge clk_i);
        #1;
        valid_i = 1'b0; is_call_i = 1'b0; is_return_i = 1'b0; clr_i = 1'b0;
    endtask

    task automatic doReset();
        rst_i = 1'b1;
        valid_i = 1'b0; is_call_i = 1'b0; is_return_i = 1'b0; clr_i = 1'b0;
        en_i = 1'b1; debug_mode_i = 1'b0; priv_lvl_i = 2'b00;
        link_addr_i = '0; ret_target_i = '0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
    endtask

    initial begin
        doReset();
        checkOutput("rst_fault", {31'd0, fault_o}, 32'd0);
        checkOutput("rst_faddr", fault_addr_o, 32'd0);
        checkOutput("rst_depth", {28'd0, depth_o}, 32'd0);
        checkOutput("rst_ovf", {31'd0, overflow_o}, 32'd0);

        // Nested call/return pair, all matching
        applyStimulus(1, 1, 0, 32'h80001004, 0);
        checkOutput("nest_d1", {28'd0, depth_o}, 32'd1);
        applyStimulus(1, 1, 0, 32'h80002008, 0);
        checkOutput("nest_d2", {28'd0, depth_o}, 32'd2);
        applyStimulus(1, 0, 1, 0, 32'h80002008);
        checkOutput("nest_d3", {28'd0, depth_o}, 32'd1);
        checkOutput("nest_f3", {31'd0, fault_o}, 32'd0);
        applyStimulus(1, 0, 1, 0, 32'h80001004);
        checkOutput("nest_d4", {28'd0, depth_o}, 32'd0);
        checkOutput("nest_f4", {31'd0, fault_o}, 32'd0);

        // Mismatching return
        applyStimulus(1, 1, 0, 32'h80001004, 0);
        applyStimulus(1, 0, 1, 0, 32'h80001008);
        checkOutput("mm_fault", {31'd0, fault_o}, 32'd1);
        checkOutput("mm_faddr", fault_addr_o, 32'h80001008);
        checkOutput("mm_depth", {28'd0, depth_o}, 32'd0);
`ifdef RET_SHADOW_STACK_STICKY_EN
        applyStimulus(1, 1, 0, 32'h80005000, 0);
        checkOutput("mm_sticky_fault", {31'd0, fault_o}, 32'd1);
        checkOutput("mm_sticky_depth", {28'd0, depth_o}, 32'd0);
`else
        applyStimulus(1, 1, 0, 32'h80005000, 0);
        checkOutput("mm_pulse_fault", {31'd0, fault_o}, 32'd0);
        checkOutput("mm_pulse_faddr", fault_addr_o, 32'h80001008);
        checkOutput("mm_pulse_depth", {28'd0, depth_o}, 32'd1);
`endif

        // Overflow: 10 calls, survivors are i=2..9, two entries lost
        doReset();
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1, 1, 0, 32'h00001000 + 32'(i * 4), 0);
        end
        checkOutput("ovf_depth", {28'd0, depth_o}, 32'd8);
        checkOutput("ovf_flag", {31'd0, overflow_o}, 32'd1);
        for (int r = 1; r <= 7; r++) begin
            applyStimulus(1, 0, 1, 0, 32'h00001000 + 32'((10 - r) * 4));
            checkOutput($sformatf("ovf_ret%0d", r), {31'd0, fault_o}, 32'd0);
        end
        checkOutput("ovf_depth7", {28'd0, depth_o}, 32'd1);
        applyStimulus(1, 0, 1, 0, 32'hDEAD0000);
        checkOutput("ovf_ret8_fault", {31'd0, fault_o}, 32'd1);
        checkOutput("ovf_ret8_faddr", fault_addr_o, 32'hDEAD0000);
`ifndef RET_SHADOW_STACK_STICKY_EN
        applyStimulus(1, 0, 1, 0, 32'h11111111);
        checkOutput("ovf_ret9", {31'd0, fault_o}, 32'd0);
        applyStimulus(1, 0, 1, 0, 32'h22222222);
        checkOutput("ovf_ret10", {31'd0, fault_o}, 32'd0);
        checkOutput("ovf_keep", {31'd0, overflow_o}, 32'd1);
        applyStimulus(1, 0, 1, 0, 32'h33333333);
        checkOutput("ovf_ret11_under", {31'd0, fault_o}, 32'd1);
`endif

        // Underflow on an empty stack
        doReset();
        applyStimulus(1, 0, 1, 0, 32'h80003000);
        checkOutput("uf_fault", {31'd0, fault_o}, 32'd1);
        checkOutput("uf_faddr", fault_addr_o, 32'h80003000);

        // Back-to-back call/return, then filtered modes
        doReset();
        applyStimulus(1, 1, 0, 32'h80004000, 0);
        applyStimulus(1, 0, 1, 0, 32'h80004000);
        checkOutput("fwd_fault", {31'd0, fault_o}, 32'd0);
        checkOutput("fwd_depth", {28'd0, depth_o}, 32'd0);
        debug_mode_i = 1'b1;
        applyStimulus(1, 1, 0, 32'h80004000, 0);
        checkOutput("dbg_depth", {28'd0, depth_o}, 32'd0);
        applyStimulus(1, 0, 1, 0, 32'h80004444);
        checkOutput("dbg_fault", {31'd0, fault_o}, 32'd0);
        debug_mode_i = 1'b0;
        priv_lvl_i = 2'b11;
        applyStimulus(1, 1, 0, 32'h80004000, 0);
        checkOutput("priv_depth", {28'd0, depth_o}, 32'd0);
        applyStimulus(1, 0, 1, 0, 32'h80004444);
        checkOutput("priv_fault", {31'd0, fault_o}, 32'd0);
        priv_lvl_i = 2'b00;
        en_i = 1'b0;
        applyStimulus(1, 0, 1, 0, 32'h80004444);
        checkOutput("en_fault", {31'd0, fault_o}, 32'd0);
        en_i = 1'b1;
        applyStimulus(1, 0, 0, 32'h1, 32'h2);
        checkOutput("noop_depth", {28'd0, depth_o}, 32'd0);

        // Clear with a same-cycle call, after overflowing
        doReset();
        for (int i = 0; i < 9; i++) applyStimulus(1, 1, 0, 32'h00002000 + 32'(i), 0);
        checkOutput("clr_pre_ovf", {31'd0, overflow_o}, 32'd1);
        applyStimulus(1, 1, 0, 32'h80006000, 0, 1'b1);
        checkOutput("clr_depth", {28'd0, depth_o}, 32'd0);
        checkOutput("clr_ovf", {31'd0, overflow_o}, 32'd0);
        applyStimulus(1, 0, 1, 0, 32'h80006000);
        checkOutput("clr_uf_fault", {31'd0, fault_o}, 32'd1);

        // Coroutine swap
        doReset();
        applyStimulus(1, 1, 1, 32'hC0000000, 32'h12345678);
        checkOutput("swap_empty_fault", {31'd0, fault_o}, 32'd0);
        checkOutput("swap_empty_depth", {28'd0, depth_o}, 32'd1);
        applyStimulus(1, 1, 1, 32'hB0000000, 32'hC0000000);
        checkOutput("swap_fault", {31'd0, fault_o}, 32'd0);
        checkOutput("swap_depth", {28'd0, depth_o}, 32'd1);
        applyStimulus(1, 0, 1, 0, 32'hB0000000);
        checkOutput("swap_ret_fault", {31'd0, fault_o}, 32'd0);
        checkOutput("swap_ret_depth", {28'd0, depth_o}, 32'd0);
        applyStimulus(1, 1, 0, 32'hA0000000, 0);
        applyStimulus(1, 1, 1, 32'hA0000004, 32'hA0000008);
        checkOutput("swap_mm_fault", {31'd0, fault_o}, 32'd1);
        checkOutput("swap_mm_faddr", fault_addr_o, 32'hA0000008);

        // Reset overrides a same-cycle call
        doReset();
        applyStimulus(1, 1, 0, 32'h1000, 0);
        rst_i = 1'b1;
        applyStimulus(1, 1, 0, 32'h2000, 0);
        rst_i = 1'b0;
        checkOutput("rst_mid_depth", {28'd0, depth_o}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/ret_shadow_stack.md
# ret_shadow_stack

Hardware shadow return-address stack sitting directly downstream of the branch unit. It consumes each resolved control-flow instruction: calls push their link value, returns pop and compare against the resolved return target. A mismatch raises a registered fault that the issue/commit path uses to redirect the core to the crash handler. All checking is restricted to user-mode, non-debug execution.

## Interface
- DEPTH, 8: number of stack entries; power of two, ≥2.
- VLEN, 32: address width, equal to riscv::VLEN.
- clk_i  in  1  core clock; all state updates on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- en_i  in  1  checking enable; when low, no push, pop or fault.
- clr_i  in  1  flush the stack, e.g. on context switch; does not clear fault state.
- debug_mode_i  in  1  high suppresses push, pop and fault.
- priv_lvl_i  in  2  current privilege; only PRIV_LVL_U (2'b00) is tracked.
- valid_i  in  1  one resolved control-flow instruction this cycle.
- is_call_i  in  1  JAL/JALR with rd == x1.
- is_return_i  in  1  JALR with rd == x0 and rs1 == x1.
- link_addr_i  in  VLEN  value written to rd, already in encoded form.
- ret_target_i  in  VLEN  resolved target of the return, in the same encoding.
- fault_o  out  1  return-address mismatch or underflow.
- fault_addr_o  out  VLEN  ret_target_i of the faulting return.
- depth_o  out  $clog2(DEPTH)+1  current number of valid entries.
- overflow_o  out  1  at least one entry was discarded since the last reset or clear.

## Operation
- An event is qualified (`act`) when valid_i & en_i & ~debug_mode_i & (priv_lvl_i == U).
- Storage: circular array of DEPTH entries, VLEN bits each. Top pointer `tp` wraps modulo DEPTH. Counter `cnt` saturates at DEPTH. Counter `lost` saturates at 255.
- Push (act & is_call_i & ~is_return_i):
  - Write link_addr_i at tp+1, then tp := tp+1.
  - If cnt == DEPTH, the oldest entry is overwritten: cnt is unchanged, lost increments and overflow_o is set.
  - Otherwise cnt increments.
- Pop (act & is_return_i & ~is_call_i):
  - cnt > 0: compare entry[tp] with ret_target_i. On mismatch, fault. Then tp := tp-1 and cnt := cnt-1.
  - cnt == 0 and lost > 0: entry was discarded, so the return is not checked; lost decrements.
  - cnt == 0 and lost == 0: underflow fault.
- Swap (act & is_call_i & is_return_i, coroutine-style): check against entry[tp] as for a pop, then overwrite entry[tp] with link_addr_i. tp and cnt are unchanged. If cnt == 0, treat it as a push and skip the check.
- FSM has two states, RUN and FAULT:
  - RUN -> FAULT on any fault; fault_addr_o captures ret_target_i.
  - In FAULT, stack updates are frozen.
  - FAULT -> RUN only via rst_i (see Configuration for the non-sticky build).
- clr_i: sets tp, cnt and lost to 0 and clears overflow_o. clr_i has priority over a same-cycle event; the event is dropped.
- valid_i with neither is_call_i nor is_return_i is a no-op.

## Timing
- Reset values: fault_o=0, fault_addr_o=0, depth_o=0, overflow_o=0, state RUN, tp=0, lost=0. Array contents are don't-care.
- Single-cycle processing with no back-pressure. One event is accepted every cycle.
- fault_o and fault_addr_o are registered and assert the cycle after the faulting return is presented.
- depth_o and overflow_o reflect the event in the following cycle.
- A push in cycle N followed by a return in cycle N+1 must compare against the value pushed in N. Array read-after-write forwarding is required.
- rst_i mid-stream overrides every input in the same edge.

## Configuration
- RET_SHADOW_STACK_STICKY_EN defined: FAULT is sticky. fault_o stays high and the stack stays frozen until rst_i.
- Not defined: there is no FAULT state. fault_o is a one-cycle pulse per faulting return, fault_addr_o holds the last faulting address, and the stack keeps operating. The pop still occurs on a mismatch.

## Test plan
- Calls pushing 0x80001004 then 0x80002008, followed by returns to 0x80002008 then 0x80001004 -> fault_o stays 0; depth_o goes 1, 2, 1, 0.
- Call pushing 0x80001004, then a return to 0x80001008 -> fault_o=1 and fault_addr_o=0x80001008 one cycle later. Sticky build: fault_o held and a further call does not change depth_o.
- DEPTH=8 with 10 calls, then 10 matching returns -> overflow_o=1 and depth_o stays 8. The first 8 returns are checked (injecting a mismatch on return 8 faults); the last 2 are unchecked with no fault.
- Return with an empty stack and lost=0 -> underflow fault; fault_addr_o equals ret_target_i.
- Call at cycle N and a matching return at N+1 -> no fault (forwarding path). Same sequence with debug_mode_i=1 or priv_lvl_i=M -> depth_o stays 0 and no fault.
- clr_i asserted together with a call after 3 pushes -> depth_o=0 and overflow_o=0. A subsequent return underflows and faults.
